// File: rtl/dat_transfer_scheduler_if.sv
// Scheduler <-> DAT physical layer signal bundle.
interface dat_transfer_scheduler_if;
  logic       strobe_out;
  logic [3:0] blocks_out;
  logic       multiple_out;
  logic       writeRead_out;
  logic       ack_to_phys;
  logic       phys_complete;
  logic       phys_ack;
  logic       DATA_TIMEOUT;

  // Scheduler side
  modport master (
    output strobe_out, blocks_out, multiple_out, writeRead_out, ack_to_phys,
    input  phys_complete, phys_ack, DATA_TIMEOUT
  );

  // Physical layer side
  modport slave (
    input  strobe_out, blocks_out, multiple_out, writeRead_out, ack_to_phys,
    output phys_complete, phys_ack, DATA_TIMEOUT
  );
endinterface

// File: rtl/dat_transfer_scheduler.sv
// Block-by-block DAT transfer scheduler: issues one single-block request to the
// physical layer per block, retries timed-out blocks and reports completion.
module dat_transfer_scheduler #(
  parameter int unsigned RETRY_MAX = 2
) (
  input  logic                             sd_clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             abort,
  input  logic                             write_read,
  input  logic [3:0]                       block_count,
  dat_transfer_scheduler_if.master         phys,
  output logic                             idle_out,
  output logic                             busy,
  output logic                             done,
  output logic                             error,
  output logic [3:0]                       blocks_done
);

  localparam int unsigned RW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARM       = 3'd1,
    WAIT_PHYS = 3'd2,
    HANDSHAKE = 3'd3,
    GAP       = 3'd4,
    DONE      = 3'd5,
    ERROR     = 3'd6
  } state_t;

  state_t        state;
  logic [RW-1:0] retry_cnt;
  logic [3:0]    count_q;

  // Every request is a single block; multi-block mode is never used.
  assign phys.blocks_out   = 4'd1;
  assign phys.multiple_out = 1'b0;

  // State machine; each output register is loaded with the value of the state being entered.
  always_ff @(posedge sd_clock or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      retry_cnt          <= '0;
      count_q            <= 4'd0;
      blocks_done        <= 4'd0;
      phys.writeRead_out <= 1'b0;
      phys.strobe_out    <= 1'b0;
      phys.ack_to_phys   <= 1'b0;
      idle_out           <= 1'b1;
      busy               <= 1'b0;
      done               <= 1'b0;
      error              <= 1'b0;
    end else begin
      phys.strobe_out  <= 1'b0;
      phys.ack_to_phys <= 1'b0;
      done             <= 1'b0;
      if (abort) begin
        state    <= IDLE;
        idle_out <= 1'b1;
        busy     <= 1'b0;
        error    <= 1'b0;
      end else begin
        case (state)
          IDLE, ERROR: begin
            if (start) begin
              phys.writeRead_out <= write_read;
              count_q            <= block_count;
              blocks_done        <= 4'd0;
              retry_cnt          <= '0;
              idle_out           <= 1'b0;
              error              <= 1'b0;
              if (block_count == 4'd0) begin
                state <= DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else begin
                state           <= ARM;
                phys.strobe_out <= 1'b1;
                busy            <= 1'b1;
              end
            end
          end
          ARM: state <= WAIT_PHYS;
          WAIT_PHYS: begin
            // A completed block is accepted even if a timeout fires in the same cycle.
            if (phys.phys_complete) begin
              state            <= HANDSHAKE;
              phys.ack_to_phys <= 1'b1;
            end else if (phys.DATA_TIMEOUT) begin
              if (retry_cnt < RW'(RETRY_MAX)) begin
                retry_cnt <= retry_cnt + RW'(1);
                state     <= GAP;
              end else begin
                state <= ERROR;
                error <= 1'b1;
                busy  <= 1'b0;
              end
            end
          end
          HANDSHAKE: begin
            if (phys.phys_ack) begin
              blocks_done <= blocks_done + 4'd1;
              retry_cnt   <= '0;
              if ((blocks_done + 4'd1) == count_q) begin
                state <= DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else begin
                state <= GAP;
              end
            end else begin
              phys.ack_to_phys <= 1'b1;
            end
          end
          GAP: begin
            state           <= ARM;
            phys.strobe_out <= 1'b1;
          end
          DONE: begin
            state    <= IDLE;
            idle_out <= 1'b1;
          end
          default: begin
            state    <= IDLE;
            idle_out <= 1'b1;
            busy     <= 1'b0;
            error    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dat_transfer_scheduler.sv
// Scoreboard bench for dat_transfer_scheduler with a scripted physical-layer responder.
module tb_dat_transfer_scheduler;

  localparam int EV_NONE   = 0;
  localparam int EV_STROBE = 1;
  localparam int EV_DONE   = 2;
  localparam int EV_ERROR  = 3;

  localparam int P_COMPLETE = 0;
  localparam int P_TIMEOUT  = 1;
  localparam int P_BOTH     = 2;

  typedef struct {
    int         kind;
    logic       wr;
    logic [3:0] bd;
  } ev_t;

  typedef struct {
    int kind;
    int delay;
  } plan_t;

  logic       sd_clock;
  logic       reset;
  logic       start;
  logic       abort;
  logic       write_read;
  logic [3:0] block_count;
  logic       idle_out;
  logic       busy;
  logic       done;
  logic       error;
  logic [3:0] blocks_done;

  dat_transfer_scheduler_if pif ();

  dat_transfer_scheduler #(.RETRY_MAX(2)) dut (
    .sd_clock    (sd_clock),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .write_read  (write_read),
    .block_count (block_count),
    .phys        (pif),
    .idle_out    (idle_out),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .blocks_done (blocks_done)
  );

  int    total;
  int    bad;
  ev_t   exp_q[$];
  plan_t plan_q[$];
  bit    ack_enable;

  initial sd_clock = 1'b0;
  always #5 sd_clock = ~sd_clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input logic wr, input logic [3:0] bd);
    ev_t e;
    e.kind = kind;
    e.wr   = wr;
    e.bd   = bd;
    exp_q.push_back(e);
  endtask

  task automatic add_plan(input int kind, input int delay);
    plan_t p;
    p.kind  = kind;
    p.delay = delay;
    plan_q.push_back(p);
  endtask

  task automatic score(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_event", 32'(kind), 32'(EV_NONE));
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 32'(kind), 32'(e.kind));
      check("event_blocks_done", 32'(blocks_done), 32'(e.bd));
      if (kind == EV_STROBE) check("strobe_dir", 32'(pif.writeRead_out), 32'(e.wr));
    end
  endtask

  // Monitor: pops the expected-event queue whenever the DUT shows strobe, done or a new error.
  initial begin
    logic err_prev;
    err_prev = 1'b0;
    forever begin
      @(negedge sd_clock);
      if (!reset) begin
        if (pif.strobe_out) score(EV_STROBE);
        if (done) score(EV_DONE);
        if (error && !err_prev) score(EV_ERROR);
      end
      err_prev = error;
    end
  end

  // Physical layer responder: answers each strobe from plan_q; acks one cycle after ack_to_phys.
  initial begin
    int    cnt;
    int    kind;
    int    ack_age;
    bit    active;
    plan_t p;
    cnt = 0; kind = 0; ack_age = 0; active = 0;
    pif.phys_complete = 1'b0;
    pif.phys_ack      = 1'b0;
    pif.DATA_TIMEOUT  = 1'b0;
    forever begin
      @(posedge sd_clock); #1;
      pif.phys_complete = 1'b0;
      pif.DATA_TIMEOUT  = 1'b0;
      pif.phys_ack      = 1'b0;
      if (reset) begin
        active  = 0;
        ack_age = 0;
      end else begin
        if (active) begin
          cnt--;
          if (cnt == 0) begin
            active = 0;
            pif.phys_complete = (kind != P_TIMEOUT);
            pif.DATA_TIMEOUT  = (kind != P_COMPLETE);
          end
        end
        if (pif.strobe_out && plan_q.size() > 0) begin
          p = plan_q.pop_front();
          kind = p.kind;
          cnt = p.delay;
          active = 1;
        end
        if (pif.ack_to_phys) ack_age++;
        else ack_age = 0;
        pif.phys_ack = ack_enable && (ack_age >= 2);
      end
    end
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge sd_clock); #1;
    end
  endtask

  task automatic do_start(input logic wr, input logic [3:0] cnt);
    @(posedge sd_clock); #1;
    write_read = wr; block_count = cnt; start = 1'b1;
    @(posedge sd_clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_end(input string name);
    int k;
    k = 0;
    while (!(idle_out || error) && k < 300) begin
      @(posedge sd_clock); #1;
      k++;
    end
    check(name, 32'(idle_out || error), 32'd1);
  endtask

  // Global safety net against a hung run.
  initial begin
    #400000;
    $display("FAIL watchdog: got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    total = 0; bad = 0; ack_enable = 1;
    reset = 1'b1; start = 1'b0; abort = 1'b0; write_read = 1'b0; block_count = 4'd0;
    @(negedge sd_clock); @(negedge sd_clock);
    check("rst_idle_out", 32'(idle_out), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_strobe", 32'(pif.strobe_out), 32'd0);
    check("rst_ack", 32'(pif.ack_to_phys), 32'd0);
    check("rst_blocks_out", 32'(pif.blocks_out), 32'd1);
    check("rst_multiple", 32'(pif.multiple_out), 32'd0);
    check("rst_blocks_done", 32'(blocks_done), 32'd0);
    check("rst_dir", 32'(pif.writeRead_out), 32'd0);
    @(posedge sd_clock); #1;
    reset = 1'b0;

    // Three-block write, clean completions; a stray start mid-transfer is ignored.
    add_plan(P_COMPLETE, 5); add_plan(P_COMPLETE, 5); add_plan(P_COMPLETE, 5);
    expect_ev(EV_STROBE, 1'b1, 4'd0); expect_ev(EV_STROBE, 1'b1, 4'd1);
    expect_ev(EV_STROBE, 1'b1, 4'd2); expect_ev(EV_DONE, 1'b1, 4'd3);
    do_start(1'b1, 4'd3);
    check("t1_busy", 32'(busy), 32'd1);
    @(posedge sd_clock); #1;
    start = 1'b1; write_read = 1'b0; block_count = 4'd0;
    @(posedge sd_clock); #1;
    start = 1'b0;
    wait_end("t1_end");
    check("t1_busy_after", 32'(busy), 32'd0);
    check("t1_blocks_done", 32'(blocks_done), 32'd3);
    check("t1_error", 32'(error), 32'd0);

    // One block read, two timeouts then success.
    add_plan(P_TIMEOUT, 3); add_plan(P_TIMEOUT, 3); add_plan(P_COMPLETE, 5);
    expect_ev(EV_STROBE, 1'b0, 4'd0); expect_ev(EV_STROBE, 1'b0, 4'd0);
    expect_ev(EV_STROBE, 1'b0, 4'd0); expect_ev(EV_DONE, 1'b0, 4'd1);
    do_start(1'b0, 4'd1);
    wait_end("t2_end");
    check("t2_error", 32'(error), 32'd0);
    check("t2_blocks_done", 32'(blocks_done), 32'd1);

    // Two blocks, second block times out three times -> ERROR; then restart from ERROR.
    add_plan(P_COMPLETE, 5);
    add_plan(P_TIMEOUT, 3); add_plan(P_TIMEOUT, 3); add_plan(P_TIMEOUT, 3);
    expect_ev(EV_STROBE, 1'b1, 4'd0); expect_ev(EV_STROBE, 1'b1, 4'd1);
    expect_ev(EV_STROBE, 1'b1, 4'd1); expect_ev(EV_STROBE, 1'b1, 4'd1);
    expect_ev(EV_ERROR, 1'b1, 4'd1);
    do_start(1'b1, 4'd2);
    wait_end("t3_end");
    check("t3_error", 32'(error), 32'd1);
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_blocks_done", 32'(blocks_done), 32'd1);
    cycles(2);
    add_plan(P_COMPLETE, 5);
    expect_ev(EV_STROBE, 1'b0, 4'd0); expect_ev(EV_DONE, 1'b0, 4'd1);
    do_start(1'b0, 4'd1);
    check("t3_error_cleared", 32'(error), 32'd0);
    wait_end("t3b_end");
    check("t3b_idle", 32'(idle_out), 32'd1);

    // Zero blocks: done on the cycle after start is sampled, no strobe.
    expect_ev(EV_DONE, 1'b0, 4'd0);
    @(posedge sd_clock); #1;
    write_read = 1'b0; block_count = 4'd0; start = 1'b1;
    @(posedge sd_clock); #1;
    start = 1'b0;
    check("t4_done", 32'(done), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    @(posedge sd_clock); #1;
    check("t4_done_low", 32'(done), 32'd0);
    check("t4_idle", 32'(idle_out), 32'd1);

    // Complete and timeout together enter HANDSHAKE without a retry; abort there.
    ack_enable = 0;
    add_plan(P_COMPLETE, 5); add_plan(P_TIMEOUT, 3); add_plan(P_BOTH, 5);
    expect_ev(EV_STROBE, 1'b0, 4'd0); expect_ev(EV_STROBE, 1'b0, 4'd1);
    expect_ev(EV_STROBE, 1'b0, 4'd1);
    ack_enable = 1;
    do_start(1'b0, 4'd2);
    k = 0;
    while (blocks_done != 4'd1 && k < 200) begin
      @(posedge sd_clock); #1;
      k++;
    end
    ack_enable = 0;
    k = 0;
    while (!pif.ack_to_phys && k < 200) begin
      @(posedge sd_clock); #1;
      k++;
    end
    check("t5_handshake", 32'(pif.ack_to_phys), 32'd1);
    check("t5_retry_cnt", 32'(dut.retry_cnt), 32'd1);
    cycles(2);
    check("t5_ack_held", 32'(pif.ack_to_phys), 32'd1);
    abort = 1'b1;
    @(posedge sd_clock); #1;
    abort = 1'b0;
    check("t5_abort_idle", 32'(idle_out), 32'd1);
    check("t5_abort_ack", 32'(pif.ack_to_phys), 32'd0);
    check("t5_abort_done", 32'(done), 32'd0);
    check("t5_abort_busy", 32'(busy), 32'd0);
    check("t5_blocks_kept", 32'(blocks_done), 32'd1);
    ack_enable = 1;
    cycles(3);

    // Asynchronous reset while waiting on the second block.
    add_plan(P_COMPLETE, 5); add_plan(P_COMPLETE, 40);
    expect_ev(EV_STROBE, 1'b1, 4'd0); expect_ev(EV_STROBE, 1'b1, 4'd1);
    do_start(1'b1, 4'd2);
    k = 0;
    while (!(pif.strobe_out && blocks_done == 4'd1) && k < 200) begin
      @(posedge sd_clock); #1;
      k++;
    end
    check("t6_second_strobe", 32'(pif.strobe_out), 32'd1);
    @(posedge sd_clock); #1;
    @(posedge sd_clock); #3;
    reset = 1'b1;
    #1;
    check("t6_rst_idle", 32'(idle_out), 32'd1);
    check("t6_rst_blocks", 32'(blocks_done), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_dir", 32'(pif.writeRead_out), 32'd0);
    @(posedge sd_clock); #1;
    reset = 1'b0;
    plan_q.delete();
    cycles(10);
    check("t6_after_idle", 32'(idle_out), 32'd1);
    check("t6_after_error", 32'(error), 32'd0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
